// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
// Bus initiator for main memory. Two CPU-side requesters share one memory port:
//   port I : instruction fetch (read-only)
//   port D : data load/store
// A granted request is latched onto the mem_* lines, held for MEM_LAT clocks,
// then read data is captured (loads/fetches) and a one-cycle ack is returned.
// Every access takes MEM_LAT+2 clocks: IDLE (grant), ACCESS x MEM_LAT, DONE (ack).
//
// Optional feature (macro MEM_REQ_RR_EN):
//   defined   : round-robin arbitration through a 1-bit last-grant register
//   undefined : fixed D-over-I priority
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             fetch request and word address
//   i_ack/i_rdata            fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata data request, store flag, address, store data
//   d_ack/d_rdata            data completion pulse and load data
//   mem_addr/mem_we/mem_wdata memory address, write enable, write data
//   mem_rdata                memory read data
//   busy                     high while the controller is not IDLE
// -----------------------------------------------------------------------------
module mem_req_ctrl #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // MEM_LAT is at most 15, so the remaining-cycles counter needs 4 bits.
  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_is_d_q, gnt_is_d_d;   // 1 = current transaction belongs to D
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ack_q, i_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;
  logic                pick_d_s;                 // arbitration result in IDLE

`ifdef MEM_REQ_RR_EN
  logic                last_d_q, last_d_d;       // 1 = D granted last, reset = I

  // Round-robin choice: on a tie the port not granted last wins.
  always_comb begin
    if (d_req && i_req) begin
      pick_d_s = ~last_d_q;
    end else begin
      pick_d_s = d_req;
    end
  end
`else
  // Fixed priority: D wins whenever it requests.
  always_comb begin
    pick_d_s = d_req;
  end
`endif

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_is_d_d  = gnt_is_d_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_REQ_RR_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (d_req || i_req) begin
          gnt_is_d_d = pick_d_s;
`ifdef MEM_REQ_RR_EN
          last_d_d   = pick_d_s;
`endif
          if (pick_d_s) begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
          end else begin
            mem_addr_d  = i_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = {DATA_W{1'b0}};
          end
          cnt_d   = CNT_LOAD;
          state_d = ST_ACCESS;
        end else begin
          mem_we_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        // mem_we_q is high for the whole ACCESS phase only on a store.
        if (cnt_q == {CNT_W{1'b0}}) begin
          if (gnt_is_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
          mem_we_d = 1'b0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_DONE: begin
        // Requests are not sampled here; the requester is dropping req.
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      gnt_is_d_q  <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_we_q    <= 1'b0;
      mem_wdata_q <= {DATA_W{1'b0}};
      i_ack_q     <= 1'b0;
      i_rdata_q   <= {DATA_W{1'b0}};
      d_ack_q     <= 1'b0;
      d_rdata_q   <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
`ifdef MEM_REQ_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_is_d_q  <= gnt_is_d_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
`ifdef MEM_REQ_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_req_ctrl
// Directed bench for mem_req_ctrl. Two instances share clock and reset:
//   u_dut1 : MEM_LAT = 1 (fetch, arbitration)
//   u_dut3 : MEM_LAT = 3 (store/load, reset abort, address-change robustness)
// Each instance drives its own small memory model indexed by addr[7:0].
// Arbitration expectations follow MEM_REQ_RR_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        i_req1, d_req1, d_we1;
  logic [21:0] i_addr1, d_addr1;
  logic [31:0] d_wdata1;
  logic        i_ack1, d_ack1, mem_we1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [21:0] mem_addr1;

  logic        i_req3, d_req3, d_we3;
  logic [21:0] i_addr3, d_addr3;
  logic [31:0] d_wdata3;
  logic        i_ack3, d_ack3, mem_we3, busy3;
  logic [31:0] i_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [21:0] mem_addr3;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_W(22), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_req_ctrl #(.ADDR_W(22), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory models: combinational read, write on the clock edge.
  assign mem_rdata1 = mem1[mem_addr1[7:0]];
  assign mem_rdata3 = mem3[mem_addr3[7:0]];

  // Memory 1 gets its fetch word preloaded while reset is held.
  always @(posedge clk) begin
    if (rst) mem1[8'h10] <= 32'hDEADBEEF;
    else if (mem_we1) mem1[mem_addr1[7:0]] <= mem_wdata1;
  end

  // Memory 3 is never touched by reset, so an aborted store is observable.
  always @(posedge clk) begin
    if (mem_we3) mem3[mem_addr3[7:0]] <= mem_wdata3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare %s", tag);
    end
  endtask

  // Advance edge-by-edge until the chosen instance acks; cyc = cycles after start.
  task automatic wait_ack(input int which, input int budget, output int cyc, output int we_cnt);
    cyc = 0;
    we_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (which == 1) begin
        if (mem_we1) we_cnt++;
        if (d_ack1 || i_ack1) begin cyc = k; break; end
      end else begin
        if (mem_we3) we_cnt++;
        if (d_ack3 || i_ack3) begin cyc = k; break; end
      end
    end
  endtask

  logic exp_d [0:3];

  initial begin
    int cyc, wec, acks;
    rst = 1'b1;
    i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0; i_addr1 = 22'd0; d_addr1 = 22'd0; d_wdata1 = 32'd0;
    i_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0; i_addr3 = 22'd0; d_addr3 = 22'd0; d_wdata3 = 32'd0;
`ifdef MEM_REQ_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_mem_we", 64'(mem_we1), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr1), 64'd0);
    chk("rst_acks", 64'({i_ack1, d_ack1, i_ack3, d_ack3}), 64'd0);
    chk("rst_rdata", 64'({i_rdata1, d_rdata3}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch read, MEM_LAT=1
    i_req1 = 1'b1; i_addr1 = 22'h000010;
    @(posedge clk); #1;
    chk("fetch_mem_addr", 64'(mem_addr1), 64'h10);
    chk("fetch_mem_we", 64'(mem_we1), 64'd0);
    chk("fetch_busy", 64'(busy1), 64'd1);
    chk("fetch_no_early_ack", 64'(i_ack1), 64'd0);
    @(posedge clk); #1;
    chk("fetch_ack", 64'(i_ack1), 64'd1);
    chk("fetch_rdata", 64'(i_rdata1), 64'hDEADBEEF);
    i_req1 = 1'b0;
    @(posedge clk); #1;
    chk("fetch_busy_fall", 64'(busy1), 64'd0);
    chk("fetch_ack_pulse", 64'(i_ack1), 64'd0);

    // Store then load at top address, MEM_LAT=3
    d_req3 = 1'b1; d_we3 = 1'b1; d_addr3 = 22'h3FFFFF; d_wdata3 = 32'h12345678;
    wait_ack(3, 12, cyc, wec);
    chk("store_ack_cycle", 64'(cyc), 64'd4);
    chk("store_we_cycles", 64'(wec), 64'd3);
    chk("store_d_ack", 64'(d_ack3), 64'd1);
    chk("store_we_low_at_ack", 64'(mem_we3), 64'd0);
    chk("store_rdata_kept", 64'(d_rdata3), 64'd0);
    chk("store_mem_content", 64'(mem3[8'hFF]), 64'h12345678);
    d_req3 = 1'b0;
    @(posedge clk); #1;
    chk("store_busy_fall", 64'(busy3), 64'd0);
    d_req3 = 1'b1; d_we3 = 1'b0; d_wdata3 = 32'hFFFFFFFF;
    wait_ack(3, 12, cyc, wec);
    chk("load_ack_cycle", 64'(cyc), 64'd4);
    chk("load_no_we", 64'(wec), 64'd0);
    chk("load_rdata", 64'(d_rdata3), 64'h12345678);
    d_req3 = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests on MEM_LAT=1
    i_req1 = 1'b1; i_addr1 = 22'h000010;
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 22'h000010;
    for (int t = 0; t < 4; t++) begin
      wait_ack(1, 10, cyc, wec);
      chk("arb_timeout", 64'(cyc != 0), 64'd1);
      chk("arb_d_ack", 64'(d_ack1), 64'(exp_d[t]));
      chk("arb_i_ack", 64'(i_ack1), 64'(!exp_d[t]));
      if (t == 3) d_req1 = 1'b0;
    end
    wait_ack(1, 10, cyc, wec);
    chk("arb_i_after_drop", 64'(i_ack1), 64'd1);
    chk("arb_i_rdata", 64'(i_rdata1), 64'hDEADBEEF);
    chk("arb_d_rdata", 64'(d_rdata1), 64'hDEADBEEF);
    i_req1 = 1'b0;
    @(posedge clk); #1;

    // Reset mid-access of a store on MEM_LAT=3
    d_req3 = 1'b1; d_we3 = 1'b1; d_addr3 = 22'h000005; d_wdata3 = 32'h11111111;
    wait_ack(3, 12, cyc, wec);
    chk("pre_store_ack", 64'(d_ack3), 64'd1);
    d_req3 = 1'b0;
    @(posedge clk); #1;
    d_req3 = 1'b1; d_wdata3 = 32'h22222222;
    @(posedge clk); #1;
    chk("abort_we_before_rst", 64'(mem_we3), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_we_async", 64'(mem_we3), 64'd0);
    chk("abort_busy", 64'(busy3), 64'd0);
    chk("abort_no_ack", 64'(d_ack3), 64'd0);
    d_req3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (d_ack3) acks++;
    end
    chk("abort_acks_after", 64'(acks), 64'd0);
    chk("abort_mem_intact", 64'(mem3[8'h05]), 64'h11111111);

    // Address change during ACCESS must not disturb the latched transaction
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 22'h3FFFFF;
    @(posedge clk); #1;
    d_addr3 = 22'h000005;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      if (d_ack3) begin
        acks++;
        d_req3 = 1'b0;
      end else begin
        chk("hold_mem_addr", 64'(mem_addr3), 64'h3FFFFF);
      end
      @(posedge clk); #1;
    end
    chk("hold_single_ack", 64'(acks), 64'd1);
    chk("hold_rdata", 64'(d_rdata3), 64'h12345678);
    chk("port_i3_idle", 64'({i_ack3, i_rdata3}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
